driver_scheduler: RTL and testbench

DRIVER_SCHEDULER -- requirements
Module: driver_scheduler

---
 rtl/driver_scheduler.sv | 104 ++++++++++
 tb/tb_driver_scheduler.sv | 129 ++++++++++++
 2 files changed

// File: rtl/driver_scheduler.sv
// driver_scheduler: sequences driver configuration writes and framebuffer bit-plane streaming.
// Define DRIVER_SCHEDULER_STATS_EN to add the 16-bit frame_count output.
module driver_scheduler #(
   parameter int POKER_MODE      = 9,
   parameter int BLANKING_CYCLES = 72,
   parameter int CONFIG_CYCLES   = 48
) (
   input  logic        clk_33,
   input  logic        rst,
   input  logic        config_req,
   output logic        config_ack,
   input  logic        frame_valid,
   output logic        frame_ack,
   output logic        cfg_en,
   output logic        new_configuration_ready,
   output logic        driver_ready,
   output logic        lat,
   output logic        busy
`ifdef DRIVER_SCHEDULER_STATS_EN
   ,
   output logic [15:0] frame_count
`endif
);
   typedef enum logic [2:0] {IDLE, CONFIG, PREP, STREAM, BLANK} state_t;
   localparam logic [9:0] CFG_LAST   = 10'(CONFIG_CYCLES - 1);
   localparam logic [9:0] BLANK_LAST = 10'(BLANKING_CYCLES - 1);
   localparam logic [3:0] PLANE_LAST = 4'(POKER_MODE - 1);
   localparam logic [5:0] WORD_LAST  = 6'd47;
   state_t state_q, state_d;
   logic [9:0] cnt_q, cnt_d;
   logic [5:0] word_q, word_d;
   logic [3:0] plane_q, plane_d;
   logic entry;
   logic config_ack_q, config_ack_d, frame_ack_q, frame_ack_d, cfg_en_q, cfg_en_d;
   logic ncr_q, ncr_d, driver_ready_q, driver_ready_d, lat_q, lat_d, busy_q, busy_d;
   always_ff @(posedge clk_33 or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         word_q         <= '0;
         plane_q        <= '0;
         config_ack_q   <= 1'b0;
         frame_ack_q    <= 1'b0;
         cfg_en_q       <= 1'b0;
         ncr_q          <= 1'b0;
         driver_ready_q <= 1'b0;
         lat_q          <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         word_q         <= word_d;
         plane_q        <= plane_d;
         config_ack_q   <= config_ack_d;
         frame_ack_q    <= frame_ack_d;
         cfg_en_q       <= cfg_en_d;
         ncr_q          <= ncr_d;
         driver_ready_q <= driver_ready_d;
         lat_q          <= lat_d;
         busy_q         <= busy_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = config_req ? CONFIG : frame_valid ? PREP : IDLE;
         CONFIG:  state_d = (cnt_q == CFG_LAST) ? IDLE : CONFIG;
         PREP:    state_d = STREAM;
         STREAM:  state_d = (word_q == WORD_LAST && plane_q == PLANE_LAST) ? BLANK : STREAM;
         BLANK:   state_d = (cnt_q == BLANK_LAST) ? IDLE : BLANK;
         default: state_d = IDLE;
      endcase
      entry   = state_d != state_q;
      // counters only run in the states that use them, so none can wrap while idling
      cnt_d   = (entry || !(state_q inside {CONFIG, BLANK})) ? '0 : cnt_q + 10'd1;
      word_d  = (entry || state_q != STREAM || word_q == WORD_LAST) ? '0 : word_q + 6'd1;
      plane_d = (entry || state_q != STREAM) ? '0 : plane_q + 4'(word_q == WORD_LAST);
   end
   always_comb begin
      cfg_en_d       = state_d == CONFIG;
      config_ack_d   = state_d == CONFIG && cnt_d == CFG_LAST;
      ncr_d          = state_d == PREP;
      driver_ready_d = state_d == STREAM;
      lat_d          = state_d == STREAM && word_d == WORD_LAST;
      frame_ack_d    = state_d == BLANK && cnt_d == BLANK_LAST;
      busy_d         = state_d != IDLE;
   end
   assign config_ack              = config_ack_q;
   assign frame_ack               = frame_ack_q;
   assign cfg_en                  = cfg_en_q;
   assign new_configuration_ready = ncr_q;
   assign driver_ready            = driver_ready_q;
   assign lat                     = lat_q;
   assign busy                    = busy_q;
`ifdef DRIVER_SCHEDULER_STATS_EN
   logic [15:0] frame_count_q, frame_count_d;
   always_comb frame_count_d = frame_count_q + 16'(frame_ack_d);
   always_ff @(posedge clk_33 or posedge rst) begin
      if (rst) frame_count_q <= '0;
      else     frame_count_q <= frame_count_d;
   end
   assign frame_count = frame_count_q;
`endif
endmodule

// File: tb/tb_driver_scheduler.sv
// tb_driver_scheduler: table-driven trace checks for driver_scheduler plus reset/stats sequences.
module tb_driver_scheduler;
   localparam logic [6:0] B = 7'h40, C = 7'h20, K = 7'h10, N = 7'h08, D = 7'h04, L = 7'h02, F = 7'h01;
   logic clk_33 = 1'b0, rst = 1'b1;
   logic config_req = 1'b0, frame_valid = 1'b0, config_req2 = 1'b0, frame_valid2 = 1'b0;
   logic config_ack, frame_ack, cfg_en, ncr, driver_ready, lat, busy;
   logic config_ack2, frame_ack2, cfg_en2, ncr2, driver_ready2, lat2, busy2;
   logic [6:0] o1, o2;
   logic [6:0] tr [0:3][0:600];
   int checks = 0, errors = 0;
   int len [4] = '{510, 55, 560, 55};
   typedef struct {int s; int cyc; logic [6:0] exp;} vec_t;
   vec_t vt[$];
`ifdef DRIVER_SCHEDULER_STATS_EN
   logic [15:0] frame_count, frame_count2;
`endif
   assign o1 = {busy, cfg_en, config_ack, ncr, driver_ready, lat, frame_ack};
   assign o2 = {busy2, cfg_en2, config_ack2, ncr2, driver_ready2, lat2, frame_ack2};
   always #15 clk_33 = ~clk_33;
   driver_scheduler dut (
      .clk_33(clk_33), .rst(rst), .config_req(config_req), .config_ack(config_ack),
      .frame_valid(frame_valid), .frame_ack(frame_ack), .cfg_en(cfg_en),
      .new_configuration_ready(ncr), .driver_ready(driver_ready), .lat(lat), .busy(busy)
`ifdef DRIVER_SCHEDULER_STATS_EN
      , .frame_count(frame_count)
`endif
   );
   driver_scheduler #(.POKER_MODE(1), .BLANKING_CYCLES(1)) dut2 (
      .clk_33(clk_33), .rst(rst), .config_req(config_req2), .config_ack(config_ack2),
      .frame_valid(frame_valid2), .frame_ack(frame_ack2), .cfg_en(cfg_en2),
      .new_configuration_ready(ncr2), .driver_ready(driver_ready2), .lat(lat2), .busy(busy2)
`ifdef DRIVER_SCHEDULER_STATS_EN
      , .frame_count(frame_count2)
`endif
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   task automatic do_reset(input logic cr, input logic fv, input logic fv2);
      rst = 1'b1;
      #1 chk("reset_async", {o1, o2}, 0);
      repeat (2) @(posedge clk_33);
      #1 chk("reset_hold", {o1, o2}, 0);
      config_req = cr;
      frame_valid = fv;
      frame_valid2 = fv2;
      rst = 1'b0;
   endtask
   task automatic run_scen(input int s);
      for (int n = 1; n <= len[s]; n++) begin
         @(posedge clk_33);
         #1 tr[s][n] = (s == 3) ? o2 : o1;
         if (s == 1 && n == 1) config_req = 1'b0;
         if (s == 2 && n == 101) config_req = 1'b1;
         if (s == 2 && n == 507) config_req = 1'b0;
      end
   endtask
   initial begin
      int n, lat_cnt, dr_cnt, excl;
      vt.push_back('{0, 1, B|N});   vt.push_back('{0, 2, B|D});     vt.push_back('{0, 48, B|D});
      vt.push_back('{0, 49, B|D|L}); vt.push_back('{0, 50, B|D});   vt.push_back('{0, 97, B|D|L});
      vt.push_back('{0, 433, B|D|L}); vt.push_back('{0, 434, B});   vt.push_back('{0, 505, B|F});
      vt.push_back('{0, 506, 7'h0}); vt.push_back('{0, 507, B|N});
      vt.push_back('{1, 1, B|C});   vt.push_back('{1, 47, B|C});    vt.push_back('{1, 48, B|C|K});
      vt.push_back('{1, 49, 7'h0}); vt.push_back('{1, 50, B|N});    vt.push_back('{1, 51, B|D});
      vt.push_back('{2, 101, B|D}); vt.push_back('{2, 102, B|D});   vt.push_back('{2, 145, B|D|L});
      vt.push_back('{2, 433, B|D|L}); vt.push_back('{2, 505, B|F}); vt.push_back('{2, 506, 7'h0});
      vt.push_back('{2, 507, B|C}); vt.push_back('{2, 554, B|C|K}); vt.push_back('{2, 555, 7'h0});
      vt.push_back('{2, 556, B|N});
      vt.push_back('{3, 1, B|N});   vt.push_back('{3, 2, B|D});     vt.push_back('{3, 48, B|D});
      vt.push_back('{3, 49, B|D|L}); vt.push_back('{3, 50, B|F});   vt.push_back('{3, 51, 7'h0});
      vt.push_back('{3, 52, B|N});
      do_reset(1'b0, 1'b1, 1'b0); run_scen(0);
      do_reset(1'b1, 1'b1, 1'b0); run_scen(1);
      do_reset(1'b0, 1'b1, 1'b0); run_scen(2);
      do_reset(1'b0, 1'b0, 1'b1); run_scen(3);
      foreach (vt[i]) chk($sformatf("trace_s%0d_cyc%0d", vt[i].s, vt[i].cyc), tr[vt[i].s][vt[i].cyc], vt[i].exp);
      for (int s = 0; s < 4; s++) begin
         if (s == 1) continue;
         lat_cnt = 0;
         dr_cnt = 0;
         for (int c = 1; c <= (s == 3 ? 50 : 505); c++) begin
            lat_cnt += int'(tr[s][c][1]);
            dr_cnt += int'(tr[s][c][2]);
         end
         chk($sformatf("lat_count_s%0d", s), lat_cnt, s == 3 ? 1 : 9);
         chk($sformatf("dr_count_s%0d", s), dr_cnt, s == 3 ? 48 : 432);
      end
      excl = 0;
      for (int s = 0; s < 4; s++)
         for (int c = 1; c <= len[s]; c++)
            if (tr[s][c][5] && (tr[s][c][2] || tr[s][c][1])) excl++;
      chk("cfg_en_exclusive", excl, 0);
      do_reset(1'b0, 1'b1, 1'b0);
      repeat (202) @(posedge clk_33);
      #1 chk("rst_mid_pre", o1, B|D);
      rst = 1'b1;
      #1 chk("rst_mid_async", o1, 0);
      @(posedge clk_33);
      #1 chk("rst_mid_hold", o1, 0);
      rst = 1'b0;
      @(posedge clk_33);
      #1 chk("rst_mid_prep", o1, B|N);
      n = 1;
      while (!frame_ack && n < 700) begin
         @(posedge clk_33);
         #1 n++;
      end
      chk("rst_mid_ack_cycle", n, 505);
`ifdef DRIVER_SCHEDULER_STATS_EN
      chk("frame_count_one", frame_count, 1);
      force dut.frame_count_q = 16'hffff;
      #1 release dut.frame_count_q;
      @(posedge clk_33);
      n = 0;
      while (!frame_ack && n < 700) begin
         @(posedge clk_33);
         #1 n++;
      end
      chk("frame_count_wrap", frame_count, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
